// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result/flags and one operation in flight.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier for op 111.
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ans,
   output logic             zero,
   output logic             ovf,
   output logic             err,
   output logic             busy
);

`ifdef ALU_SEQ_MUL_EN
   typedef enum logic [1:0] {S_IDLE = 2'b00, S_MUL = 2'b01, S_DONE = 2'b10} state_t;
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
`else
   typedef enum logic [1:0] {S_IDLE = 2'b00, S_DONE = 2'b10} state_t;
`endif

   function automatic logic [WIDTH-1:0] alu_result(input logic [2:0] f_op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      r = {WIDTH{1'b0}};
      case (f_op)
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  r = a ^ b;
         3'b011:  r = a + b;
         3'b100:  r = a - b;
         3'b101:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         3'b110:  r = a << b[SHW-1:0];
         default: r = {WIDTH{1'b0}};
      endcase
      return r;
   endfunction

   function automatic logic alu_ovf(input logic [2:0] f_op,
                                    input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic [WIDTH-1:0] r);
      logic v;
      case (f_op)
         3'b011:  v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         3'b100:  v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         default: v = 1'b0;
      endcase
      return v;
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] ans_q, ans_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] res_s;
   logic             accept_s;

`ifdef ALU_SEQ_MUL_EN
   logic [WIDTH-1:0] ma_q, ma_d;
   logic [WIDTH-1:0] mb_q, mb_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_sum_s;
`endif

   assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
   assign accept_s  = in_valid && in_ready;
   assign res_s     = alu_result(op, inA, inB);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign ans       = ans_q;
   assign zero      = zero_q;
   assign ovf       = ovf_q;
   assign err       = err_q;
`ifdef ALU_SEQ_MUL_EN
   assign acc_sum_s = acc_q + (mb_q[0] ? ma_q : {WIDTH{1'b0}});
`endif

   // Next-state, result and multiplier datapath decode.
   always_comb begin
      state_d = state_q;
      ans_d   = ans_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
`ifdef ALU_SEQ_MUL_EN
      ma_d    = ma_q;
      mb_d    = mb_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept_s) begin
`ifdef ALU_SEQ_MUL_EN
               if (op == 3'b111) begin
                  ma_d    = inA;
                  mb_d    = inB;
                  acc_d   = {WIDTH{1'b0}};
                  cnt_d   = {SHW{1'b0}};
                  state_d = S_MUL;
               end else begin
                  ans_d   = res_s;
                  zero_d  = (res_s == {WIDTH{1'b0}});
                  ovf_d   = alu_ovf(op, inA, inB, res_s);
                  err_d   = 1'b0;
                  state_d = S_DONE;
               end
`else
               // Op 111 has no multiplier here: alu_result yields 0 and err flags it.
               ans_d   = res_s;
               zero_d  = (res_s == {WIDTH{1'b0}});
               ovf_d   = alu_ovf(op, inA, inB, res_s);
               err_d   = (op == 3'b111);
               state_d = S_DONE;
`endif
            end else if ((state_q == S_DONE) && out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = state_q;
            end
         end
`ifdef ALU_SEQ_MUL_EN
         S_MUL: begin
            acc_d = acc_sum_s;
            ma_d  = ma_q << 1'b1;
            mb_d  = mb_q >> 1'b1;
            cnt_d = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
            if (cnt_q == CNT_LAST) begin
               ans_d   = acc_sum_s;
               zero_d  = (acc_sum_s == {WIDTH{1'b0}});
               ovf_d   = 1'b0;
               err_d   = 1'b0;
               state_d = S_DONE;
            end else begin
               state_d = S_MUL;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // State, result and flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ans_q   <= {WIDTH{1'b0}};
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ans_q   <= ans_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

`ifdef ALU_SEQ_MUL_EN
   // Multiplier working registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ma_q  <= {WIDTH{1'b0}};
         mb_q  <= {WIDTH{1'b0}};
         acc_q <= {WIDTH{1'b0}};
         cnt_q <= {SHW{1'b0}};
      end else begin
         ma_q  <= ma_d;
         mb_q  <= mb_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end
`endif

endmodule
